// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding alu_32_bit: resolves EX/MEM/WB operand forwarding
// at capture time, inserts a bubble on load-use hazards, and honours stall/flush.
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_aluCode,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [DATA_W-1:0] id_rsData,
    input  logic [DATA_W-1:0] id_rtData,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_useImm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              stall,
    input  logic              flush,
    input  logic              exm_regWrite,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_regWrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] ex_result,
    output logic [3:0]        aluCode,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] storeData,
    output logic              ex_valid,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic [REG_W-1:0]  ex_rd
);

    logic [3:0]        r_alu_code;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_W-1:0]  r_ex_rd;
    logic              r_ex_valid;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;

    logic              w_load_use;
    logic              w_ex_fwd_en;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Highest-priority producer wins; register 0 is hard-wired and never forwards.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_W-1:0]  s,
        input logic [DATA_W-1:0] rf,
        input logic              ex_en,
        input logic [REG_W-1:0]  ex_dst,
        input logic [DATA_W-1:0] ex_val,
        input logic              mem_en,
        input logic [REG_W-1:0]  mem_dst,
        input logic [DATA_W-1:0] mem_val,
        input logic              wb_en,
        input logic [REG_W-1:0]  wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] sel;
        sel = rf;
        if (s != '0) begin
            if (ex_en && ex_dst == s)        sel = ex_val;
            else if (mem_en && mem_dst == s) sel = mem_val;
            else if (wb_en && wb_dst == s)   sel = wb_val;
        end
        return sel;
    endfunction

    // A load in EX has no result yet, so it is excluded from EX forwarding.
    assign w_ex_fwd_en = r_ex_valid & r_ex_reg_write & ~r_ex_mem_read;

    assign w_load_use = id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) &
                        ((r_ex_rd == id_rs) | ((r_ex_rd == id_rt) & ~id_useImm));

    // Handshake: decode holds id_* stable while id_valid is high; an instruction
    // transfers on a rising edge where id_valid & id_ready (flush still kills it).
    assign id_ready = ~stall & ~w_load_use;

    always_comb begin
        w_fwd_rs = fwd_sel(id_rs, id_rsData, w_ex_fwd_en, r_ex_rd, ex_result,
                           exm_regWrite, exm_rd, exm_result, wb_regWrite, wb_rd, wb_data);
        w_fwd_rt = fwd_sel(id_rt, id_rtData, w_ex_fwd_en, r_ex_rd, ex_result,
                           exm_regWrite, exm_rd, exm_result, wb_regWrite, wb_rd, wb_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_code     <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_store_data   <= '0;
            r_ex_rd        <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
        end else if (flush || (!stall && (w_load_use || !id_valid))) begin
            // Bubble: control cleared, datapath fields left as they were.
            r_ex_rd        <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
        end else if (!stall) begin
            r_alu_code     <= id_aluCode;
            r_a            <= w_fwd_rs;
            r_b            <= id_useImm ? id_imm : w_fwd_rt;
            r_store_data   <= w_fwd_rt;
            r_ex_rd        <= id_rd;
            r_ex_valid     <= 1'b1;
            r_ex_reg_write <= id_regWrite;
            r_ex_mem_read  <= id_memRead;
        end
    end

    assign aluCode     = r_alu_code;
    assign a           = r_a;
    assign b           = r_b;
    assign storeData   = r_store_data;
    assign ex_valid    = r_ex_valid;
    assign ex_regWrite = r_ex_reg_write;
    assign ex_memRead  = r_ex_mem_read;
    assign ex_rd       = r_ex_rd;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register that drives alu_32_bit directly: registered aluCode, a and b.
- Resolves operand forwarding from the EX, MEM and WB stages at capture time.
- Detects load-use hazards and inserts bubbles.
- Supports external stall and flush, with a valid/ready handshake to the decode stage.

Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  decode stage presents an instruction
- id_ready  output  1  stage accepts id_* this cycle
- id_aluCode  input  4  ALU operation for the incoming instruction
- id_rs, id_rt  input  REG_W  source register indices
- id_rsData, id_rtData  input  DATA_W  register-file read data
- id_imm  input  DATA_W  sign/zero-extended immediate
- id_useImm  input  1  b takes id_imm instead of rt
- id_rd  input  REG_W  destination register
- id_regWrite, id_memRead  input  1  write-back enable; instruction is a load
- stall  input  1  downstream hold
- flush  input  1  kill the incoming instruction (branch redirect)
- exm_regWrite  input  1  MEM-stage instruction writes a register
- exm_rd  input  REG_W  MEM-stage destination
- exm_result  input  DATA_W  MEM-stage result
- wb_regWrite  input  1  WB-stage instruction writes a register
- wb_rd  input  REG_W  WB-stage destination
- wb_data  input  DATA_W  WB-stage data
- ex_result  input  DATA_W  combinational alu_32_bit result for the instruction now held here
- aluCode  output  4  registered, to alu_32_bit
- a, b  output  DATA_W  registered, signed, to alu_32_bit
- storeData  output  DATA_W  registered forwarded rt value (for stores)
- ex_valid, ex_regWrite, ex_memRead  output  1  registered control
- ex_rd  output  REG_W  registered destination

Behaviour:
- Reset (async, immediate): every output register is 0 (aluCode, a, b, storeData, ex_rd, ex_valid, ex_regWrite, ex_memRead). id_ready is combinational and follows its equation.
- Load-use hazard, combinational. loadUse = id_valid & ex_valid & ex_memRead & ex_rd != 0 & (ex_rd == id_rs | (ex_rd == id_rt & !id_useImm)).
- id_ready = !stall & !loadUse. A transfer happens when id_valid & id_ready.
- Forwarding is done per source s (rs, rt) in strict priority order:
  - EX: ex_valid & ex_regWrite & !ex_memRead & ex_rd == s -> ex_result
  - MEM: exm_regWrite & exm_rd == s -> exm_result
  - WB: wb_regWrite & wb_rd == s -> wb_data
  - otherwise: register-file data
- Register 0 never forwards; s == 0 always yields the register-file data.
- Operand selection:
  - a = fwd(rs)
  - b = id_useImm ? id_imm : fwd(rt)
  - storeData = fwd(rt)
- Clock edge, first match wins:
  1. flush: load a bubble. ex_valid, ex_regWrite, ex_memRead = 0; ex_rd = 0; aluCode, a, b, storeData are don't-care and hold.
  2. stall: hold every output register. Flush overrides stall when both are asserted.
  3. loadUse: load a bubble (as in 1). Decode holds its instruction because id_ready = 0.
  4. id_valid: capture all fields, ex_valid = 1.
  5. otherwise: load a bubble.
- Latency: one cycle from id_* capture to ALU inputs. A load-use dependency costs exactly one bubble; the following cycle forwards via MEM.
- Arithmetic: no width conversion; operands pass through bit-exact. Signedness is the ALU's concern.
- Reset mid-operation discards the in-flight instruction with no partial update.

Test Plan:
- Reset then capture: reset high 2 cycles, all outputs 0. Capture id_aluCode=0010, rsData=5, rtData=9, no matching hazards → next cycle aluCode=0010, a=5, b=9, ex_valid=1, ALU result 14.
- EX forwarding:
  - Setup: instruction 1 writes $8 (ex_result=16); instruction 2 reads rs=$8, rsData=0 (stale).
  - Response: a=16.
  - Priority check: also drive wb_rd=8, wb_data=99 → a stays 16.
- Immediate and $0:
  - useImm=1, imm=-7, rtData=32 → b=-7, storeData=32.
  - rs=0 with exm_rd=0, exm_regWrite=1, exm_result=55 → a = rsData.
- Load-use:
  - Setup: EX holds a load to $9; incoming instruction reads rt=$9.
  - Same cycle: id_ready=0.
  - Next edge: ex_valid=0.
  - Following edge: b comes from exm_result (set to 123) → b=123, ex_valid=1.
- Stall/flush:
  - Stall 3 cycles → outputs unchanged, id_ready=0.
  - Assert stall & flush together → ex_valid=0.
  - Reset asserted mid-stall → outputs 0 immediately, without waiting for a clock edge.
